conv_func: RTL and testbench
============================

Name: conv_func

Overview:
- Post-CIM function unit for a conv layer.
- After a CIM compute, reads one output pixel (all output channels) from the CIM output buffer.
- Sums vertical-tile partial sums, requantises, applies activation, then writes the pixel into the next conv layer's per-channel input line buffers in a single cycle.
- Transmit side of the ibuf write interface (per-channel write-enable plus data); counts pixels per frame.

Parameters:
- output_channels, 4, number of CIM output columns; equals next layer's input channels.
- img_width, 4, output feature-map width; a frame is img_width**2 pixels.
- xbar_size, 256, crossbar columns per horizontal tile.
- v_cim_tiles, 2, vertical tiles whose partial sums are added.
- h_cim_tiles, (output_channels+xbar_size-1)/xbar_size, horizontal tiles.
- datatype_size, 8, CIM output element width, signed two's complement.
- output_datatype_size, 8, written element width, signed.
- requant_shift, 0, arithmetic right shift applied to the sum.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  pulse: CIM output buffer holds a new pixel.
- i_data  in  [datatype_size-1:0] x [v_cim_tiles][h_cim_tiles]  CIM output buffer read data, valid 1 cycle after address.
- o_cim_rd_addr  out  $clog2(xbar_size)  CIM output buffer column address.
- i_next_busy  in  1  next layer cannot accept a write.
- o_ibuf_we  out  1 x [output_channels]  per-channel ibuf write enable.
- o_ibuf_wr_data  out  [output_datatype_size-1:0] x [output_channels]  per-channel write data.
- o_busy  out  1  block busy; upstream must not overwrite the CIM output buffer.
- o_pixel_cnt  out  $clog2(img_width**2)  pixels written in current frame.
- o_frame_done  out  1  one-cycle pulse with the last pixel's write.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE.
  - o_busy, o_ibuf_we, o_frame_done = 0.
  - o_cim_rd_addr, o_pixel_cnt, o_ibuf_wr_data = 0.
  - Capture registers cleared.
  - Reset mid-operation aborts the pixel; no partial write is emitted.
- States: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - i_start=1 sampled → READ, o_busy=1 from the next cycle.
  - i_start while not IDLE is ignored.
- READ:
  - Lasts output_channels cycles; cycle k drives o_cim_rd_addr = k % xbar_size.
  - Registered tile index h = k / xbar_size.
  - READ → DRAIN after k = output_channels-1.
- Capture:
  - One cycle after address k, computes sum_k = Σ over v of sign-extended i_data[v][h].
  - Accumulator width: datatype_size + $clog2(v_cim_tiles) + 1, so no overflow.
  - Then arithmetic shift right by requant_shift.
  - Then activation/saturation (see Optional Feature); the result is stored in channel k's data register.
- DRAIN: one cycle to capture the last channel → WRITE.
- WRITE:
  - If i_next_busy=0: all o_ibuf_we bits = 1 for exactly one cycle with o_ibuf_wr_data valid; then IDLE and o_busy=0 the following cycle.
  - If i_next_busy=1: hold in WRITE with we=0 and data stable until it drops.
  - With i_next_busy=0 throughout, o_ibuf_we is high in cycle C+2 after the i_start sample edge, where C = output_channels.
- o_ibuf_wr_data holds its last value outside write cycles.
- Pixel counter:
  - o_pixel_cnt increments on each write.
  - On the write where it equals img_width**2-1: o_frame_done=1 that cycle, counter wraps to 0.
- i_start in the same cycle as a WRITE completion is ignored; upstream waits for o_busy=0.

Optional Feature:
- Macro CONV_FUNC_RELU_EN.
- Defined: ReLU. Negative shifted sums → 0; positive sums saturate to 2^(output_datatype_size-1)-1.
- Undefined: signed saturation to [-2^(output_datatype_size-1), 2^(output_datatype_size-1)-1].

Test Plan:
- Basic pixel, defaults:
  - Stimulus: v0 columns {10,-20,100,5}, v1 {3,-1,100,-128}, one i_start, i_next_busy=0.
  - Response: o_ibuf_we=4'b1111 in cycle 6 after start.
  - Data without RELU: {13,-21,127,-123}. With CONV_FUNC_RELU_EN: {13,0,127,0}.
  - o_busy=0 in cycle 7.
- Backpressure: same data with i_next_busy=1 for 10 cycles from cycle 3 → we stays 0 and data stable; one write the cycle after i_next_busy falls; exactly one write total.
- Requant: requant_shift=2, sums {13,-21,200,-123} → {3,-6,50,-31} without RELU.
- Frame wrap: img_width=2, 4 pixels back-to-back → o_pixel_cnt 1,2,3,0; o_frame_done only on the 4th write.
- Ignore restart: i_start re-pulsed in cycles 2 and 4 while busy → single write; address sequence 0,1,2,3 unaltered.
- Reset mid-READ: rst=0 at cycle 3 → outputs return to reset values immediately; no we pulse; next i_start runs a clean pixel.

Source files
------------

// File: rtl/conv_func.sv
// conv_func: post-CIM function unit. It reads one output pixel column by column, sums the vertical tiles,
// requantises and clamps each channel, then writes all channels to the next layer in one cycle.
// Optional macro CONV_FUNC_RELU_EN selects ReLU clamping; when undefined, signed saturation is used.
module conv_func #(
  parameter int output_channels      = 4,
  parameter int img_width            = 4,
  parameter int xbar_size            = 256,
  parameter int v_cim_tiles          = 2,
  parameter int h_cim_tiles          = (output_channels + xbar_size - 1) / xbar_size,
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 8,
  parameter int requant_shift        = 0,
  localparam int ADDR_W = (xbar_size > 1) ? $clog2(xbar_size) : 1,
  localparam int NPIX   = img_width * img_width,
  localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int IN_W   = v_cim_tiles * h_cim_tiles * datatype_size,
  localparam int OUT_W  = output_channels * output_datatype_size
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [IN_W-1:0]            i_data,
  output logic [ADDR_W-1:0]          o_cim_rd_addr,
  input  logic                       i_next_busy,
  output logic [output_channels-1:0] o_ibuf_we,
  output logic [OUT_W-1:0]           o_ibuf_wr_data,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_pixel_cnt,
  output logic                       o_frame_done
);

  localparam int IDX_W = (output_channels > 1) ? $clog2(output_channels) : 1;
  localparam int H_W   = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
  localparam int ACC_W = datatype_size + $clog2(v_cim_tiles) + 1;
  localparam int ODW   = output_datatype_size;
  localparam longint OMAX = (64'sd1 <<< (ODW - 1)) - 64'sd1;
  localparam longint OMIN = -(64'sd1 <<< (ODW - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          k_q;
  logic [IDX_W-1:0]          cap_idx_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [H_W-1:0]            h_q;
  logic [H_W-1:0]            cap_h_q;
  logic                      cap_vld_q;
  logic                      busy_q;
  logic                      we_q;
  logic                      done_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [OUT_W-1:0]          wr_data_q;
  logic [ODW-1:0]            cap_q [output_channels];
  logic [ODW-1:0]            cap_d [output_channels];
  logic [OUT_W-1:0]          cap_flat_s;

  logic [datatype_size-1:0]  elem_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   sh_s;
  longint                    sh_l;
  longint                    res_l;
  logic [ODW-1:0]            proc_s;
  logic                      issue_s;
  logic                      last_ch_s;

  // Channel arithmetic for the column read one cycle earlier: tile sum, requant shift, clamp.
  always_comb begin
    elem_s = '0;
    sum_s  = '0;
    for (int v = 0; v < v_cim_tiles; v++) begin
      elem_s = i_data[(v * h_cim_tiles + int'(cap_h_q)) * datatype_size +: datatype_size];
      sum_s  = sum_s + {{(ACC_W - datatype_size){elem_s[datatype_size-1]}}, elem_s};
    end
    sh_s = sum_s >>> requant_shift;
    sh_l = {{(64 - ACC_W){sh_s[ACC_W-1]}}, sh_s};
`ifdef CONV_FUNC_RELU_EN
    if (sh_l < 64'sd0) begin
      res_l = 64'sd0;
    end else if (sh_l > OMAX) begin
      res_l = OMAX;
    end else begin
      res_l = sh_l;
    end
`else
    if (sh_l < OMIN) begin
      res_l = OMIN;
    end else if (sh_l > OMAX) begin
      res_l = OMAX;
    end else begin
      res_l = sh_l;
    end
`endif
    proc_s = res_l[ODW-1:0];
  end

  // Capture-register next state; the flattened view already contains the channel landing this cycle.
  always_comb begin
    cap_flat_s = '0;
    for (int k = 0; k < output_channels; k++) begin
      cap_d[k] = (cap_vld_q && (cap_idx_q == IDX_W'(k))) ? proc_s : cap_q[k];
      cap_flat_s[k * ODW +: ODW] = cap_d[k];
    end
  end

  // A write is issued from DRAIN or a stalled WRITE once the next layer is free.
  always_comb begin
    issue_s   = ((state_q == S_DRAIN) || ((state_q == S_WRITE) && !we_q)) && !i_next_busy;
    last_ch_s = (k_q == IDX_W'(output_channels - 1));
  end

  // Control FSM, address generation, capture registers, write outputs and pixel counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cap_idx_q <= '0;
      addr_q    <= '0;
      h_q       <= '0;
      cap_h_q   <= '0;
      cap_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      wr_data_q <= '0;
      for (int k = 0; k < output_channels; k++) begin
        cap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < output_channels; k++) begin
        cap_q[k] <= cap_d[k];
      end

      if (issue_s) begin
        we_q      <= 1'b1;
        wr_data_q <= cap_flat_s;
        done_q    <= (cnt_q == CNT_W'(NPIX - 1));
        cnt_q     <= (cnt_q == CNT_W'(NPIX - 1)) ? '0 : cnt_q + CNT_W'(1);
      end else begin
        we_q   <= 1'b0;
        done_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cap_vld_q <= 1'b0;
          if (i_start) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
            k_q     <= '0;
            addr_q  <= '0;
            h_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_READ: begin
          cap_vld_q <= 1'b1;
          cap_idx_q <= k_q;
          cap_h_q   <= h_q;
          if (last_ch_s) begin
            state_q <= S_DRAIN;
          end else begin
            k_q <= k_q + IDX_W'(1);
            // Column address wraps per horizontal tile; the tile index advances with it.
            if (addr_q == ADDR_W'(xbar_size - 1)) begin
              addr_q <= '0;
              h_q    <= h_q + H_W'(1);
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          cap_vld_q <= 1'b0;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          cap_vld_q <= 1'b0;
          if (we_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WRITE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          cap_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_cim_rd_addr  = addr_q;
  assign o_ibuf_we      = {output_channels{we_q}};
  assign o_ibuf_wr_data = wr_data_q;
  assign o_busy         = busy_q;
  assign o_pixel_cnt    = cnt_q;
  assign o_frame_done   = done_q;

endmodule

// File: tb/tb_conv_func.sv
// Bench for conv_func: a default instance plus one with requant_shift=2 and img_width=2.
module tb_conv_func;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, nb_a, nb_b;
  logic [15:0] data_a, data_b;
  logic [7:0]  addr_a, addr_b, rd_a, rd_b;
  logic [3:0]  we_a, we_b;
  logic [31:0] wd_a, wd_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [3:0]  cnt_a;
  logic [1:0]  cnt_b;

  logic signed [7:0] pix_a [2][4];
  logic signed [7:0] pix_b [2][4];

  int total = 0;
  int bad   = 0;
  int cnt_m [2];
  int npix  [2];

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] sat;
    logic [31:0] relu;
  } vec_t;
  vec_t tbl [4];

  conv_func dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_data(data_a), .o_cim_rd_addr(addr_a),
    .i_next_busy(nb_a), .o_ibuf_we(we_a), .o_ibuf_wr_data(wd_a), .o_busy(busy_a),
    .o_pixel_cnt(cnt_a), .o_frame_done(done_a)
  );

  conv_func #(.img_width(2), .requant_shift(2)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_data(data_b), .o_cim_rd_addr(addr_b),
    .i_next_busy(nb_b), .o_ibuf_we(we_b), .o_ibuf_wr_data(wd_b), .o_busy(busy_b),
    .o_pixel_cnt(cnt_b), .o_frame_done(done_b)
  );

  // CIM output buffer model: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    rd_a <= addr_a;
    rd_b <= addr_b;
  end

  always_comb begin
    data_a = {(rd_a < 8'd4) ? pix_a[1][rd_a[1:0]] : 8'h00, (rd_a < 8'd4) ? pix_a[0][rd_a[1:0]] : 8'h00};
    data_b = {(rd_b < 8'd4) ? pix_b[1][rd_b[1:0]] : 8'h00, (rd_b < 8'd4) ? pix_b[0][rd_b[1:0]] : 8'h00};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input bit sel, input logic [31:0] v0, input logic [31:0] v1);
    for (int k = 0; k < 4; k++) begin
      if (sel) begin
        pix_b[0][k] = v0[k*8 +: 8];
        pix_b[1][k] = v1[k*8 +: 8];
      end else begin
        pix_a[0][k] = v0[k*8 +: 8];
        pix_a[1][k] = v1[k*8 +: 8];
      end
    end
  endtask

  // Reference: sum the two tiles, arithmetic shift, clamp to the 8-bit output range.
  function automatic logic [31:0] model(input bit sel, input int shift);
    logic [31:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (sel) s = int'(pix_b[0][k]) + int'(pix_b[1][k]);
      else     s = int'(pix_a[0][k]) + int'(pix_a[1][k]);
      s = s >>> shift;
`ifdef CONV_FUNC_RELU_EN
      if (s < 0) s = 0;
      else if (s > 127) s = 127;
`else
      if (s < -128) s = -128;
      else if (s > 127) s = 127;
`endif
      r[k*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  // One pixel starting from an idle DUT; observation happens on negedges, cycle n after the start edge.
  task automatic run_pixel(input bit sel, input int bp_s, input int bp_l, input logic [31:0] exp,
                           input bit addr_chk, input bit restart, input string tag);
    int w, nwr;
    bit exp_done;
    logic [31:0] held, wd;
    logic [3:0] we;
    logic [7:0] addr;
    logic busy, done;
    logic [3:0] cnt;
    w = 6;
    while ((w - 1 >= bp_s) && (w - 1 < bp_s + bp_l)) w++;
    exp_done = (cnt_m[sel] == npix[sel] - 1);
    cnt_m[sel] = (cnt_m[sel] + 1) % npix[sel];
    nwr = 0;
    held = '0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= w + 1; n++) begin
      @(negedge clk);
      if (sel) begin
        start_b = restart && (n == 2 || n == 4);
        nb_b = (n >= bp_s) && (n < bp_s + bp_l);
        we = we_b; wd = wd_b; addr = addr_b; busy = busy_b; done = done_b; cnt = {2'b00, cnt_b};
      end else begin
        start_a = restart && (n == 2 || n == 4);
        nb_a = (n >= bp_s) && (n < bp_s + bp_l);
        we = we_a; wd = wd_a; addr = addr_a; busy = busy_a; done = done_a; cnt = cnt_a;
      end
      if (we != 4'h0) nwr++;
      if (addr_chk && n <= 4) chk({tag, ".addr"}, {24'h0, addr}, n - 1);
      if (n == 1) chk({tag, ".busy_on"}, {31'h0, busy}, 32'h1);
      if (n == 5) held = wd;
      if (n > 5 && n < w) begin
        chk({tag, ".hold_we"}, {28'h0, we}, 32'h0);
        chk({tag, ".hold_data"}, wd, held);
      end
      if (n == w) begin
        chk({tag, ".we"}, {28'h0, we}, 32'hF);
        chk({tag, ".data"}, wd, exp);
        chk({tag, ".cnt"}, {28'h0, cnt}, cnt_m[sel]);
        chk({tag, ".done"}, {31'h0, done}, {31'h0, exp_done});
        chk({tag, ".busy_w"}, {31'h0, busy}, 32'h1);
      end
      if (n == w + 1) begin
        chk({tag, ".busy_off"}, {31'h0, busy}, 32'h0);
        chk({tag, ".done_off"}, {31'h0, done}, 32'h0);
      end
    end
    chk({tag, ".nwrites"}, nwr, 1);
    nb_a = 1'b0;
    nb_b = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    npix[0] = 16; npix[1] = 4;
    cnt_m[0] = 0; cnt_m[1] = 0;
    tbl[0] = '{v0: {8'sd5, 8'sd100, -8'sd20, 8'sd10}, v1: {8'h80, 8'sd100, -8'sd1, 8'sd3},
               sat: {-8'sd123, 8'sd127, -8'sd21, 8'sd13}, relu: {8'sd0, 8'sd127, 8'sd0, 8'sd13}};
    tbl[1] = '{v0: {8'sd127, 8'sd127, 8'h80, 8'h80}, v1: {8'sd0, 8'sd127, 8'sd0, 8'h80},
               sat: {8'sd127, 8'sd127, 8'h80, 8'h80}, relu: {8'sd127, 8'sd127, 8'sd0, 8'sd0}};
    tbl[2] = '{v0: {8'sd64, -8'sd1, 8'sd1, 8'sd0}, v1: {8'sd63, -8'sd1, -8'sd1, 8'sd0},
               sat: {8'sd127, -8'sd2, 8'sd0, 8'sd0}, relu: {8'sd127, 8'sd0, 8'sd0, 8'sd0}};
    tbl[3] = '{v0: {8'sd7, -8'sd100, 8'sd50, -8'sd64}, v1: {-8'sd8, -8'sd29, 8'sd77, -8'sd65},
               sat: {-8'sd1, 8'h80, 8'sd127, 8'h80}, relu: {8'sd0, 8'sd0, 8'sd127, 8'sd0}};
    load(1'b0, tbl[0].v0, tbl[0].v1);
    load(1'b1, tbl[0].v0, tbl[0].v1);

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; nb_a = 1'b0; nb_b = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'h0, busy_a}, 32'h0);
    chk("rst.we", {28'h0, we_a}, 32'h0);
    chk("rst.data", wd_a, 32'h0);
    chk("rst.addr", {24'h0, addr_a}, 32'h0);
    chk("rst.cnt", {28'h0, cnt_a}, 32'h0);
    chk("rst.done", {31'h0, done_a}, 32'h0);
    chk("rst.b_data", wd_b, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      load(1'b0, tbl[i].v0, tbl[i].v1);
`ifdef CONV_FUNC_RELU_EN
      e = tbl[i].relu;
`else
      e = tbl[i].sat;
`endif
      run_pixel(1'b0, 100, 0, e, i == 0, 1'b0, $sformatf("tbl%0d", i));
    end

    // Backpressure for 10 cycles from cycle 3, then a restart attempt during the read.
    load(1'b0, tbl[0].v0, tbl[0].v1);
    e = model(1'b0, 0);
    run_pixel(1'b0, 3, 10, e, 1'b1, 1'b0, "bp");
    run_pixel(1'b0, 100, 0, e, 1'b1, 1'b1, "restart");

    for (int i = 0; i < 20; i++) begin
      load(1'b0, $urandom, $urandom);
      e = model(1'b0, 0);
      run_pixel(1'b0, $urandom_range(3, 8), $urandom_range(0, 5), e, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // Shift-2 instance with a 4-pixel frame: requant pixel first, then three more to wrap.
    load(1'b1, tbl[0].v0, tbl[0].v1);
`ifdef CONV_FUNC_RELU_EN
    e = {8'sd0, 8'sd50, 8'sd0, 8'sd3};
`else
    e = {-8'sd31, 8'sd50, -8'sd6, 8'sd3};
`endif
    run_pixel(1'b1, 100, 0, e, 1'b1, 1'b0, "rq0");
    for (int i = 1; i < 4; i++) begin
      load(1'b1, $urandom, $urandom);
      e = model(1'b1, 2);
      run_pixel(1'b1, 100, 0, e, 1'b0, 1'b0, $sformatf("rq%0d", i));
    end

    // Reset in the middle of a read aborts the pixel.
    load(1'b0, tbl[1].v0, tbl[1].v1);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.busy", {31'h0, busy_a}, 32'h0);
    chk("midrst.we", {28'h0, we_a}, 32'h0);
    chk("midrst.addr", {24'h0, addr_a}, 32'h0);
    chk("midrst.data", wd_a, 32'h0);
    chk("midrst.cnt", {28'h0, cnt_a}, 32'h0);
    cnt_m[0] = 0; cnt_m[1] = 0;
    @(negedge clk);
    chk("midrst.we2", {28'h0, we_a}, 32'h0);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("midrst.no_we", {28'h0, we_a}, 32'h0);
    end
    e = model(1'b0, 0);
    run_pixel(1'b0, 100, 0, e, 1'b1, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
